// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// It holds PC, IR, the operand latches (A/B), the ALU output latch and the memory data register.
// The control unit, register file and ALU stay combinational outside this block.
//
// Ports
//   clock, reset                     system clock, synchronous active-high reset
//   imem_req/addr/rdata/ready        instruction fetch handshake (addr = pc)
//   inst, pc                         instruction register and current instruction address
//   cu_m2reg/wmem/wreg/pcsource      control-unit decode of inst
//   ext_imm, rf_qa, rf_qb            immediate and register file read data
//   alu_result                       ALU output, computed from op_a/op_b
//   op_a, op_b                       latched operands
//   dmem_req/we/addr/wdata/rdata/ready  data memory handshake
//   rf_we, wb_data                   register file write port
//   instret                          retired instruction counter
//   state                            FSM state (0 FETCH .. 4 WB)
//
// state  | meaning
// FETCH  | imem_req high, wait for imem_ready, load IR
// DECODE | latch register operands into A/B
// EXEC   | latch ALU result; memory ops go to MEM, others to WB
// MEM    | dmem_req high, wait for dmem_ready, latch load data
// WB     | register write, PC update, retire
module mc_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,
    input  logic             cu_m2reg,
    input  logic             cu_wmem,
    input  logic             cu_wreg,
    input  logic [1:0]       cu_pcsource,
    input  logic [XLEN-1:0]  ext_imm,
    input  logic [XLEN-1:0]  rf_qa,
    input  logic [XLEN-1:0]  rf_qb,
    input  logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [XLEN-1:0]  op_a_q, op_a_d;
    logic [XLEN-1:0]  op_b_q, op_b_d;
    logic [XLEN-1:0]  aluout_q, aluout_d;
    logic [XLEN-1:0]  mdr_q, mdr_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  next_pc;

    // The top two immediate bits fall off the word-offset shift.
    logic unused_imm_bits;
    assign unused_imm_bits = ^ext_imm[XLEN-1:XLEN-2];

    always_comb begin
        pc4     = pc_q + XLEN'(4);
        next_pc = pc4;
        unique case (cu_pcsource)
            2'b00:   next_pc = pc4;
            2'b01:   next_pc = pc4 + {ext_imm[XLEN-3:0], 2'b00};
            2'b10:   next_pc = RESET_VEC;
            default: next_pc = {pc4[XLEN-1:28], inst_q[25:0], 2'b00};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        aluout_d  = aluout_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_a_d  = rf_qa;
                op_b_d  = rf_qb;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                aluout_d = alu_result;
                state_d  = (cu_m2reg || cu_wmem) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (cu_m2reg) mdr_d = dmem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d      = next_pc;
                instret_d = instret_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VEC;
            inst_q    <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    // Strobes decode straight from the state register; reset masks them so an
    // abandoned handshake or writeback never leaks out during the reset cycle.
    assign imem_req   = (state_q == S_FETCH) && !reset;
    assign dmem_req   = (state_q == S_MEM) && !reset;
    assign dmem_we    = (state_q == S_MEM) && cu_wmem && !reset;
    assign rf_we      = (state_q == S_WB) && cu_wreg && !reset;

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = op_b_q;
    assign wb_data    = cu_m2reg ? mdr_q : aluout_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        cu_m2reg, cu_wmem, cu_wreg;
    logic [1:0]  cu_pcsource;
    logic [31:0] ext_imm, rf_qa, rf_qb, alu_result;
    logic [31:0] op_a, op_b;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        rf_we;
    logic [31:0] wb_data;
    logic [31:0] instret;
    logic [2:0]  state;

    mc_sequencer dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .inst(inst), .pc(pc),
        .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem), .cu_wreg(cu_wreg), .cu_pcsource(cu_pcsource),
        .ext_imm(ext_imm), .rf_qa(rf_qa), .rf_qb(rf_qb), .alu_result(alu_result),
        .op_a(op_a), .op_b(op_b),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .wb_data(wb_data), .instret(instret), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m2reg, wmem, wreg;
        logic [1:0]  pcsrc;
        logic [31:0] iword, imm, qa, qb, alu, rdata;
        int          iwait, dwait;
        logic        spur;
        logic [31:0] exp_pc, exp_wb, exp_trace;
    } vec_t;

    vec_t        vecs[10];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_pc;
    logic [31:0] exp_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction starting in FETCH; per-cycle handshake responses and a state trace
    // (state+1 per nibble) are collected, then checked against the vector.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] trace, iaddr0, daddr0, wb_got;
        int cyc, ireq_n, dreq_n, dwe_n, rfwe_n;
        logic ibad, dbad, done;
        trace = 0; iaddr0 = '0; daddr0 = '0; wb_got = '0;
        cyc = 0; ireq_n = 0; dreq_n = 0; dwe_n = 0; rfwe_n = 0;
        ibad = 0; dbad = 0; done = 0;
        cu_m2reg = v.m2reg; cu_wmem = v.wmem; cu_wreg = v.wreg; cu_pcsource = v.pcsrc;
        imem_rdata = v.iword; ext_imm = v.imm; rf_qa = v.qa; rf_qb = v.qb;
        alu_result = v.alu; dmem_rdata = v.rdata;
        while (!done && cyc < 40) begin
            if (imem_req) begin
                imem_ready = (ireq_n == v.iwait);
                if (ireq_n == 0) iaddr0 = imem_addr;
                else if (imem_addr !== iaddr0) ibad = 1;
                ireq_n++;
            end else imem_ready = v.spur;
            if (dmem_req) begin
                dmem_ready = (dreq_n == v.dwait);
                if (dreq_n == 0) daddr0 = dmem_addr;
                else if (dmem_addr !== daddr0) dbad = 1;
                if (dmem_wdata !== v.qb || dmem_we !== v.wmem) dbad = 1;
                if (dmem_we) dwe_n++;
                dreq_n++;
            end else dmem_ready = v.spur;
            if (rf_we) begin
                rfwe_n++;
                wb_got = wb_data;
            end
            trace = {trace[27:0], {1'b0, state} + 4'd1};
            if (state == 3'd4) done = 1;
            cyc++;
            step();
        end
        imem_ready = 0;
        dmem_ready = 0;
        if (!done) chk($sformatf("v%0d timeout", idx), 32'(cyc), 32'd0);
        exp_ret = exp_ret + 1;
        chk($sformatf("v%0d trace", idx), trace, v.exp_trace);
        chk($sformatf("v%0d imem_addr", idx), iaddr0, cur_pc);
        chk($sformatf("v%0d imem_addr stable", idx), 32'(ibad), 32'd0);
        chk($sformatf("v%0d pc", idx), pc, v.exp_pc);
        chk($sformatf("v%0d instret", idx), instret, exp_ret);
        chk($sformatf("v%0d inst", idx), inst, v.iword);
        chk($sformatf("v%0d op_a", idx), op_a, v.qa);
        chk($sformatf("v%0d op_b", idx), op_b, v.qb);
        chk($sformatf("v%0d rf_we cycles", idx), 32'(rfwe_n), 32'(v.wreg));
        if (v.wreg) chk($sformatf("v%0d wb_data", idx), wb_got, v.exp_wb);
        chk($sformatf("v%0d dmem_req cycles", idx), 32'(dreq_n),
            (v.m2reg || v.wmem) ? 32'(v.dwait + 1) : 32'd0);
        chk($sformatf("v%0d dmem_we cycles", idx), 32'(dwe_n), v.wmem ? 32'(v.dwait + 1) : 32'd0);
        if (v.m2reg || v.wmem) begin
            chk($sformatf("v%0d dmem_addr", idx), daddr0, v.alu);
            chk($sformatf("v%0d dmem stable", idx), 32'(dbad), 32'd0);
        end
        cur_pc = v.exp_pc;
    endtask

    initial begin
        int k;
        //            m2 wm wr ps     iword         imm           qa            qb            alu           rdata         iw dw sp exp_pc        exp_wb        trace
        vecs[0] = '{0, 0, 1, 2'b00, 32'h00221820, 32'h0,        32'h5,        32'h7,        32'hC,        32'h0,        0, 0, 0, 32'h4,        32'hC,        32'h1235};
        vecs[1] = '{1, 0, 1, 2'b00, 32'h8C220010, 32'h10,       32'h0FF0,     32'h55,       32'h1000,     32'hDEADBEEF, 0, 3, 0, 32'h8,        32'hDEADBEEF, 32'h12344445};
        vecs[2] = '{0, 1, 0, 2'b00, 32'hAC220020, 32'h20,       32'h2000,     32'h12345678, 32'h2020,     32'hFFFF0000, 0, 0, 0, 32'hC,        32'h0,        32'h12345};
        vecs[3] = '{0, 0, 0, 2'b11, 32'h08000040, 32'h0,        32'h1,        32'h2,        32'h3,        32'h0,        0, 0, 0, 32'h100,      32'h0,        32'h1235};
        vecs[4] = '{0, 0, 0, 2'b01, 32'h1000FFFE, 32'hFFFFFFFE, 32'h9,        32'h9,        32'h0,        32'h0,        2, 0, 1, 32'hFC,       32'h0,        32'h111235};
        vecs[5] = '{0, 0, 1, 2'b11, 32'h0C000040, 32'h0,        32'h11,       32'h22,       32'hFFFFFFFF, 32'h0,        0, 1, 1, 32'h100,      32'hFFFFFFFF, 32'h1235};
        vecs[6] = '{1, 0, 1, 2'b10, 32'h8C230000, 32'h0,        32'h3000,     32'h44,       32'h3000,     32'h0BADF00D, 1, 0, 0, 32'h0,        32'h0BADF00D, 32'h112345};
        vecs[7] = '{0, 0, 0, 2'b01, 32'h10000000, 32'h0C000000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h30000004, 32'h0,        32'h1235};
        vecs[8] = '{0, 0, 0, 2'b11, 32'h08000040, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h30000100, 32'h0,        32'h1235};
        vecs[9] = '{0, 1, 0, 2'b00, 32'hAC240040, 32'h40,       32'h0,        32'hA5A5A5A5, 32'h40,       32'h0,        0, 2, 0, 32'h30000104, 32'h0,        32'h1234445};

        reset = 1; imem_rdata = 0; imem_ready = 0; dmem_ready = 0; dmem_rdata = 0;
        cu_m2reg = 0; cu_wmem = 1; cu_wreg = 1; cu_pcsource = 0;
        ext_imm = 0; rf_qa = 0; rf_qb = 0; alu_result = 0;

        // Reset held for three cycles; strobes must stay masked even with cu_* asserted.
        repeat (3) step();
        chk("rst pc", pc, 32'h0);
        chk("rst state", 32'(state), 32'd0);
        chk("rst instret", instret, 32'd0);
        chk("rst inst", inst, 32'd0);
        chk("rst op_a", op_a, 32'd0);
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst rf_we", 32'(rf_we), 32'd0);
        reset = 0;
        #1;
        chk("post-rst imem_req", 32'(imem_req), 32'd1);
        chk("post-rst imem_addr", imem_addr, 32'h0);

        cur_pc = 32'h0;
        exp_ret = 0;
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset while a load is stuck in MEM with no ready: the access is dropped,
        // nothing is written back and the PC returns to the reset vector.
        cu_m2reg = 1; cu_wmem = 0; cu_wreg = 1; cu_pcsource = 2'b01;
        imem_rdata = 32'h8C250000; alu_result = 32'h5000; dmem_rdata = 32'h77777777;
        imem_ready = 1; dmem_ready = 0;
        k = 0;
        while (state != 3'd3 && k < 10) begin
            step();
            k++;
        end
        imem_ready = 0;
        chk("t6 reach MEM", 32'(state), 32'd3);
        chk("t6 dmem_req held", 32'(dmem_req), 32'd1);
        reset = 1;
        #1;
        chk("t6 dmem_req masked", 32'(dmem_req), 32'd0);
        chk("t6 rf_we masked", 32'(rf_we), 32'd0);
        step();
        chk("t6 state", 32'(state), 32'd0);
        chk("t6 pc", pc, 32'h0);
        chk("t6 instret", instret, 32'd0);
        chk("t6 dmem_req", 32'(dmem_req), 32'd0);
        chk("t6 rf_we", 32'(rf_we), 32'd0);
        reset = 0;
        #1;
        chk("t6 imem_req", 32'(imem_req), 32'd1);
        chk("t6 imem_addr", imem_addr, 32'h0);

        cur_pc = 32'h0;
        exp_ret = 0;
        run_vec(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
